// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder : multi-channel fixed-latency memory responder with preload port
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS-1:0]                read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] read_address,
  output logic [NUM_CHANNELS-1:0]                read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] read_data,
  input  logic [NUM_CHANNELS-1:0]                write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] write_data,
  output logic [NUM_CHANNELS-1:0]                write_ready,
  input  logic                                   init_we,
  input  logic [ADDR_BITS-1:0]                   init_address,
  input  logic [DATA_BITS-1:0]                   init_data
);

  localparam int         DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] LOAD  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } state_t;

  logic [DATA_BITS-1:0] mem [DEPTH];

  logic [NUM_CHANNELS-1:0]                wr_en;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] wr_addr;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] wr_data;

  // Later assignments win: init first, then channels in ascending index order.
  // Writes are suppressed while reset is held so no pending write can land.
  always_ff @(posedge clk) begin
    if (init_we) mem[init_address] <= init_data;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (reset && wr_en[c]) mem[wr_addr[c]] <= wr_data[c];
    end
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    state_t               state_q, state_d;
    logic                 is_wr_q, is_wr_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 rd_rdy_q, rd_rdy_d;
    logic                 wr_rdy_q, wr_rdy_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 ch_wr_en;
    logic [ADDR_BITS-1:0] ch_wr_addr;
    logic [DATA_BITS-1:0] ch_wr_data;

    always_comb begin
      state_d    = state_q;
      is_wr_d    = is_wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      rd_rdy_d   = 1'b0;
      wr_rdy_d   = 1'b0;
      rdata_d    = rdata_q;
      ch_wr_en   = 1'b0;
      ch_wr_addr = addr_q;
      ch_wr_data = wdata_q;
      case (state_q)
        IDLE: begin
          if (read_valid[i]) begin
            addr_d  = read_address[i];
            is_wr_d = 1'b0;
            cnt_d   = LOAD;
            state_d = BUSY;
            if (LATENCY == 1) begin
              rd_rdy_d = 1'b1;
              rdata_d  = mem[read_address[i]];
              state_d  = DROP;
            end
          end else if (write_valid[i]) begin
            addr_d  = write_address[i];
            wdata_d = write_data[i];
            is_wr_d = 1'b1;
            cnt_d   = LOAD;
            state_d = BUSY;
            if (LATENCY == 1) begin
              wr_rdy_d   = 1'b1;
              ch_wr_en   = 1'b1;
              ch_wr_addr = write_address[i];
              ch_wr_data = write_data[i];
              state_d    = DROP;
            end
          end
        end
        BUSY: begin
          // The accepting edge counts as the first latency cycle.
          if (cnt_q > 4'd1) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            cnt_d   = 4'd0;
            state_d = DROP;
            if (is_wr_q) begin
              wr_rdy_d = 1'b1;
              ch_wr_en = 1'b1;
            end else begin
              rd_rdy_d = 1'b1;
              rdata_d  = mem[addr_q];
            end
          end
        end
        DROP: begin
          if (!(is_wr_q ? write_valid[i] : read_valid[i])) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q  <= IDLE;
        is_wr_q  <= 1'b0;
        addr_q   <= '0;
        wdata_q  <= '0;
        cnt_q    <= 4'd0;
        rd_rdy_q <= 1'b0;
        wr_rdy_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        state_q  <= state_d;
        is_wr_q  <= is_wr_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        cnt_q    <= cnt_d;
        rd_rdy_q <= rd_rdy_d;
        wr_rdy_q <= wr_rdy_d;
        rdata_q  <= rdata_d;
      end
    end

    assign wr_en[i]       = ch_wr_en;
    assign wr_addr[i]     = ch_wr_addr;
    assign wr_data[i]     = ch_wr_data;
    assign read_ready[i]  = rd_rdy_q;
    assign write_ready[i] = wr_rdy_q;
    assign read_data[i]   = rdata_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder : directed and random checks of mem_responder against a model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_responder;

  localparam int LAT = 2;

  logic            clk;
  logic            reset;
  logic [3:0]      read_valid;
  logic [3:0][7:0] read_address;
  logic [3:0]      read_ready;
  logic [3:0][7:0] read_data;
  logic [3:0]      write_valid;
  logic [3:0][7:0] write_address;
  logic [3:0][7:0] write_data;
  logic [3:0]      write_ready;
  logic            init_we;
  logic [7:0]      init_address;
  logic [7:0]      init_data;

  logic [7:0] ref_mem [256];
  int checks;
  int errors;

  mem_responder #(
    .ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .read_valid(read_valid), .read_address(read_address),
    .read_ready(read_ready), .read_data(read_data),
    .write_valid(write_valid), .write_address(write_address),
    .write_data(write_data), .write_ready(write_ready),
    .init_we(init_we), .init_address(init_address), .init_data(init_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    init_we = 1'b1; init_address = a; init_data = d;
    @(negedge clk);
    init_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // All selected channels are issued together; each channel reads or writes.
  task automatic xfer(input string tag, input logic [3:0] rm, input logic [3:0] wm,
                      input logic [3:0][7:0] a, input logic [3:0][7:0] d);
    logic [3:0][7:0] expd;
    for (int c = 0; c < 4; c++) expd[c] = ref_mem[a[c]];
    read_valid = rm; write_valid = wm;
    read_address = a; write_address = a; write_data = d;
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      check({tag, " early"}, {28'd0, read_ready | write_ready}, 32'd0);
    end
    @(negedge clk);
    check({tag, " rd_ready"}, {28'd0, read_ready}, {28'd0, rm});
    check({tag, " wr_ready"}, {28'd0, write_ready}, {28'd0, wm});
    for (int c = 0; c < 4; c++)
      if (rm[c]) check({tag, " rd_data"}, {24'd0, read_data[c]}, {24'd0, expd[c]});
    read_valid = 4'd0; write_valid = 4'd0;
    for (int c = 0; c < 4; c++) if (wm[c]) ref_mem[a[c]] = d[c];
    @(negedge clk);
    check({tag, " ready_clear"}, {28'd0, read_ready | write_ready}, 32'd0);
  endtask

  initial begin
    logic [3:0][7:0] a;
    logic [3:0][7:0] d;
    logic [3:0]      rm;
    logic [3:0]      wm;
    int              pulses;
    int              waited;
    checks = 0; errors = 0;
    reset = 1'b0; init_we = 1'b0; init_address = '0; init_data = '0;
    read_valid = '0; read_address = '0; write_valid = '0;
    write_address = '0; write_data = '0;
    repeat (2) @(negedge clk);
    check("reset rd_ready", {28'd0, read_ready}, 32'd0);
    check("reset wr_ready", {28'd0, write_ready}, 32'd0);
    check("reset rd_data", read_data, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    preload(8'h10, 8'hA5);
    preload(8'h00, 8'h11); preload(8'h01, 8'h22);
    preload(8'h02, 8'h33); preload(8'h03, 8'h44);
    preload(8'h20, 8'h5A); preload(8'h40, 8'h00);
    preload(8'h50, 8'h00); preload(8'h60, 8'h00);
    for (int i = 0; i < 4; i++) preload(8'h80 + 8'(i), 8'($urandom));

    a = '0; d = '0;
    a[0] = 8'h10;
    xfer("ch0 read 0x10", 4'b0001, 4'b0000, a, d);

    a = '0; d = '0; a[1] = 8'h20; d[1] = 8'h3C;
    xfer("ch1 write 0x20", 4'b0000, 4'b0010, a, d);
    a = '0; d = '0; a[2] = 8'h20;
    xfer("ch2 read 0x20", 4'b0100, 4'b0000, a, d);
    a = '0; d = '0; a[1] = 8'h20; a[2] = 8'h20; d[1] = 8'h99;
    xfer("same-edge rd/wr 0x20", 4'b0100, 4'b0010, a, d);
    a = '0; d = '0; a[0] = 8'h20;
    xfer("read back 0x20", 4'b0001, 4'b0000, a, d);

    a = {8'h03, 8'h02, 8'h01, 8'h00}; d = '0;
    xfer("all-channel read", 4'b1111, 4'b0000, a, d);

    a = '0; d = '0; a[0] = 8'h40; a[3] = 8'h40; d[0] = 8'h01; d[3] = 8'h03;
    xfer("ch0/ch3 write 0x40", 4'b0000, 4'b1001, a, d);
    a = '0; d = '0; a[1] = 8'h40;
    xfer("read back 0x40", 4'b0010, 4'b0000, a, d);

    // Held valid: exactly one pulse over the ready cycle plus six more.
    read_valid = 4'b0001; read_address = '0; read_address[0] = 8'h10;
    pulses = 0;
    for (int k = 0; k < LAT + 6; k++) begin
      @(negedge clk);
      if (read_ready[0]) pulses++;
      if (k == LAT - 1) check("held ready timing", {31'd0, read_ready[0]}, 32'd1);
    end
    check("held single pulse", pulses, 32'd1);
    read_valid = 4'd0;
    @(negedge clk);
    check("held no late pulse", {31'd0, read_ready[0]}, 32'd0);

    // Read and write both requested on ch3: read first, write after.
    read_valid = 4'b1000; write_valid = 4'b1000;
    read_address = '0; write_address = '0; write_data = '0;
    read_address[3] = 8'h01; write_address[3] = 8'h60; write_data[3] = 8'h5E;
    repeat (LAT) @(negedge clk);
    check("rw read first", {28'd0, read_ready}, 32'h8);
    check("rw write waits", {28'd0, write_ready}, 32'd0);
    check("rw read data", {24'd0, read_data[3]}, {24'd0, ref_mem[8'h01]});
    read_valid = 4'd0;
    waited = 0;
    pulses = 0;
    while (!write_ready[3] && waited < 12) begin
      @(negedge clk);
      waited++;
      if (read_ready[3]) pulses++;
    end
    check("rw write completes", {31'd0, write_ready[3]}, 32'd1);
    check("rw no second read", pulses, 32'd0);
    write_valid = 4'd0;
    ref_mem[8'h60] = 8'h5E;
    @(negedge clk);
    a = '0; d = '0; a[2] = 8'h60;
    xfer("read back 0x60", 4'b0100, 4'b0000, a, d);

    // Reset during a pending write must cancel it.
    write_valid = 4'b0010; write_address = '0; write_data = '0;
    write_address[1] = 8'h50; write_data[1] = 8'h77;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid reset rd_ready", {28'd0, read_ready}, 32'd0);
    check("mid reset wr_ready", {28'd0, write_ready}, 32'd0);
    check("mid reset rd_data", read_data, 32'd0);
    write_valid = 4'd0;
    repeat (3) @(negedge clk);
    check("reset no wr pulse", {28'd0, write_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    a = '0; d = '0; a[0] = 8'h50;
    xfer("read 0x50 after reset", 4'b0001, 4'b0000, a, d);

    // Random mixes on a small address window to force collisions.
    for (int it = 0; it < 16; it++) begin
      rm = 4'($urandom);
      wm = 4'($urandom) & ~rm;
      for (int c = 0; c < 4; c++) begin
        a[c] = 8'h80 + 8'($urandom_range(0, 3));
        d[c] = 8'($urandom);
      end
      xfer("random", rm, wm, a, d);
    end
    a = {8'h83, 8'h82, 8'h81, 8'h80}; d = '0;
    xfer("random final read", 4'b1111, 4'b0000, a, d);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
